stripe_sched: RTL and testbench
===============================

Name: stripe_sched

Overview:
- Flow-control scheduler in front of the lane datapath. Accepts a 32-bit word stream with a valid/ready handshake.
- Distributes words in strict round-robin order across NUM_LANES lanes. Each lane has a credit counter fed by the downstream per-lane FIFOs.
- On disable, pads the partial stripe group so every lane carries an equal word count and the destriper stays aligned.

Parameters:
- NUM_LANES, 2, number of output lanes (2..8).
- MAX_CREDITS, 4, per-lane credit depth; equals downstream FIFO depth.
- PAD_WORD, 32'hBC_BC_BC_BC, filler word emitted during drain.

Ports:
- clk_2f  in  1  single block clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = stripe traffic, 0 = finish the group and go idle.
- data_in  in  32  input word.
- valid_in  in  1  data_in is valid.
- ready_out  out  1  block accepts data_in this cycle.
- credit_return  in  NUM_LANES  one pulse per freed downstream slot, per lane.
- lane_data  out  32  shared lane data bus, registered.
- lane_valid  out  NUM_LANES  one-hot; indicates which lane captures lane_data.
- busy  out  1  state != IDLE.
- credit_err  out  1  sticky; a credit was returned while that lane's counter was already at MAX_CREDITS.

Behaviour:
- Reset (reset=0, async) sets:
  - state=IDLE, ptr=0, credits[i]=MAX_CREDITS.
  - lane_data=0, lane_valid=0, ready_out=0, busy=0, credit_err=0.
- States:
  - IDLE: leave to RUN when enable=1.
  - RUN: leave to DRAIN when enable=0 and ptr!=0; leave to IDLE when enable=0 and ptr==0.
  - DRAIN: return to IDLE after the pad word for lane NUM_LANES-1 issues.
- ready_out is combinational: state==RUN && enable && credits[ptr]!=0.
- accept = valid_in && ready_out. On an accept edge:
  - Next cycle, lane_data=data_in and lane_valid=(1<<ptr). Latency is 1 cycle.
  - credits[ptr] decrements.
  - ptr advances, wrapping from NUM_LANES-1 to 0.
- No accept means lane_valid=0 next cycle; lane_data holds its last value and is never driven to Z.
- Strict order: a lane without credit stalls the whole stream. The scheduler never skips to another lane.
- DRAIN:
  - Each cycle credits[ptr]!=0 holds, emit PAD_WORD on lane ptr, decrement its credit and advance ptr.
  - Stall while credit is 0. valid_in is ignored.
- Credit counter width is clog2(MAX_CREDITS+1).
- Return and consume on the same lane in the same cycle: net change is 0.
- Return while the counter is at MAX_CREDITS: the count saturates and credit_err sets. credit_err clears only on reset.
- enable rising while in DRAIN has no effect until IDLE is reached. It then enters RUN on the following cycle.
- Mid-operation reset: outputs return to reset values immediately (async). Any partial group is discarded; the downstream side is reset together with this block.

Optional Feature:
- STRIPE_STATS_EN defined adds these outputs:
  - lane_words[NUM_LANES*16-1:0]: per-lane 16-bit wrapping count of issued words, pads included.
  - stall_cycles[15:0]: cycles with valid_in && state==RUN && !ready_out; saturates at 16'hFFFF.
  - All counters clear on reset.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package stripe_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the default PAD_WORD constant;
  - the WORD_W=32 constant;
  - a function for the credit counter width.
- One sub-module, lane_credit_cnt, is instantiated NUM_LANES times:
  - Inputs: consume, ret.
  - Outputs: has_credit, overflow.
  - Implements the saturating counter.

Test Plan:
- Basic striping (NUM_LANES=2): after reset, enable=1, credits returned each cycle, 4 words A0..A3 streamed.
  -> lane_valid=01,10,01,10 one cycle after each accept; lane_data=A0..A3; ready_out stays 1.
- Credit stall: no credit_return, 10 words offered.
  -> 8 accepted (4 per lane), then ready_out=0 on lane 0.
  -> One credit_return[0] pulse releases exactly 1 word; ready_out drops again at lane 1.
- Drain padding: NUM_LANES=4, 5 words sent, then enable=0.
  -> Pad words BCBCBCBC issue on lanes 1, 2, 3; busy falls the cycle after the lane-3 pad.
  -> Total 2/2/2/2 words per lane.
- Simultaneous return and consume on lane 0 at credit=1: credit stays 1, no stall, credit_err=0.
- Over-return: credit_return[1] pulsed while credit=4.
  -> credit_err=1 and stays sticky through further traffic; reset clears it.
- Async reset mid-stream: reset=0 between clock edges during RUN.
  -> lane_valid=0, ready_out=0 immediately.
  -> After release and enable, the first word goes to lane 0.

Source files
------------

// File: rtl/stripe_pkg.sv
// Shared types and constants for the stripe scheduler.
// Holds the FSM state enum, word width, default pad word and credit width helper.
package stripe_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] PAD_WORD_DEF = 32'hBCBC_BCBC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int credit_w(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/lane_credit_cnt.sv
// Per-lane saturating credit counter, reset to MAX_CREDITS.
// Ports: clk_2f, reset (async, active-low), consume, ret -> has_credit, overflow.
module lane_credit_cnt
    import stripe_pkg::*;
#(
    parameter int MAX_CREDITS = 4
) (
    input  logic clk_2f,
    input  logic reset,
    input  logic consume,
    input  logic ret,
    output logic has_credit,
    output logic overflow
);

    localparam int CW = credit_w(MAX_CREDITS);
    localparam logic [CW-1:0] MAXV = CW'(MAX_CREDITS);

    logic [CW-1:0] r_cnt;

    // Return and consume together cancel; a lone return at full count is an error.
    always_comb begin
        has_credit = (r_cnt != '0);
        overflow   = ret && !consume && (r_cnt == MAXV);
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_cnt <= MAXV;
        end else if (ret && !consume && (r_cnt != MAXV)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (consume && !ret && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/stripe_sched.sv
// Round-robin stripe scheduler with per-lane credit flow control and drain padding.
// Ports: clk_2f, reset (async, active-low), enable, data_in/valid_in/ready_out,
//        credit_return, lane_data/lane_valid, busy, credit_err.
//        Optional (STRIPE_STATS_EN): lane_words, stall_cycles.
module stripe_sched
    import stripe_pkg::*;
#(
    parameter int                NUM_LANES   = 2,
    parameter int                MAX_CREDITS = 4,
    parameter logic [WORD_W-1:0] PAD_WORD    = PAD_WORD_DEF
) (
    input  logic                    clk_2f,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [WORD_W-1:0]       data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [NUM_LANES-1:0]    credit_return,
    output logic [WORD_W-1:0]       lane_data,
    output logic [NUM_LANES-1:0]    lane_valid,
    output logic                    busy,
`ifdef STRIPE_STATS_EN
    output logic [NUM_LANES*16-1:0] lane_words,
    output logic [15:0]             stall_cycles,
`endif
    output logic                    credit_err
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_LANES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [PW-1:0]        r_ptr;
    logic [WORD_W-1:0]    r_lane_data;
    logic [NUM_LANES-1:0] r_lane_valid;
    logic                 r_err;

    logic [NUM_LANES-1:0] w_has;
    logic [NUM_LANES-1:0] w_ovf;
    logic [NUM_LANES-1:0] w_consume;
    logic                 w_cur_credit;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_pad;
    logic                 w_issue;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_credit_cnt #(
            .MAX_CREDITS(MAX_CREDITS)
        ) u_cnt (
            .clk_2f     (clk_2f),
            .reset      (reset),
            .consume    (w_consume[g]),
            .ret        (credit_return[g]),
            .has_credit (w_has[g]),
            .overflow   (w_ovf[g])
        );
    end

    // State register
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (enable) w_next = RUN;
            end
            RUN: begin
                if (!enable) w_next = (r_ptr != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (w_pad && (r_ptr == LAST)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Output / issue logic; strict order means only lane ptr is ever considered.
    always_comb begin
        w_cur_credit = w_has[r_ptr];
        w_ready      = (r_state == RUN) && enable && w_cur_credit;
        w_pad        = (r_state == DRAIN) && w_cur_credit;
        w_accept     = valid_in && w_ready;
        w_issue      = w_accept || w_pad;
        w_consume    = w_issue ? (NUM_LANES'(1) << r_ptr) : '0;
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_ptr        <= '0;
            r_lane_data  <= '0;
            r_lane_valid <= '0;
            r_err        <= 1'b0;
        end else begin
            r_lane_valid <= w_consume;
            r_err        <= r_err | (|w_ovf);
            if (w_issue) begin
                r_lane_data <= w_accept ? data_in : PAD_WORD;
                r_ptr       <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    assign ready_out  = w_ready;
    assign busy       = (r_state != IDLE);
    assign lane_data  = r_lane_data;
    assign lane_valid = r_lane_valid;
    assign credit_err = r_err;

`ifdef STRIPE_STATS_EN
    logic [NUM_LANES*16-1:0] r_lane_words;
    logic [15:0]             r_stall;

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_lane_words <= '0;
            r_stall      <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_consume[i]) begin
                    r_lane_words[i*16 +: 16] <= r_lane_words[i*16 +: 16] + 16'd1;
                end
            end
            if (valid_in && (r_state == RUN) && !w_ready && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign lane_words   = r_lane_words;
    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_stripe_sched.sv
// Directed self-checking bench for stripe_sched.
// Uses a 2-lane instance for striping/credit/reset checks and a 4-lane one for drain.
module tb_stripe_sched;

    logic        clk;
    logic        rst2;
    logic        rst4;
    int          total;
    int          bad;

    logic        en2;
    logic [31:0] din2;
    logic        vin2;
    logic        rdy2;
    logic [1:0]  cr2;
    logic [31:0] ld2;
    logic [1:0]  lv2;
    logic        busy2;
    logic        cerr2;

    logic        en4;
    logic [31:0] din4;
    logic        vin4;
    logic        rdy4;
    logic [3:0]  cr4;
    logic [31:0] ld4;
    logic [3:0]  lv4;
    logic        busy4;
    logic        cerr4;

    int          cnt4 [4];

`ifdef STRIPE_STATS_EN
    logic [31:0] lw2;
    logic [15:0] st2;
    logic [63:0] lw4;
    logic [15:0] st4;
`endif

    stripe_sched #(.NUM_LANES(2)) u_dut2 (
        .clk_2f        (clk),
        .reset         (rst2),
        .enable        (en2),
        .data_in       (din2),
        .valid_in      (vin2),
        .ready_out     (rdy2),
        .credit_return (cr2),
        .lane_data     (ld2),
        .lane_valid    (lv2),
        .busy          (busy2),
`ifdef STRIPE_STATS_EN
        .lane_words    (lw2),
        .stall_cycles  (st2),
`endif
        .credit_err    (cerr2)
    );

    stripe_sched #(.NUM_LANES(4)) u_dut4 (
        .clk_2f        (clk),
        .reset         (rst4),
        .enable        (en4),
        .data_in       (din4),
        .valid_in      (vin4),
        .ready_out     (rdy4),
        .credit_return (cr4),
        .lane_data     (ld4),
        .lane_valid    (lv4),
        .busy          (busy4),
`ifdef STRIPE_STATS_EN
        .lane_words    (lw4),
        .stall_cycles  (st4),
`endif
        .credit_err    (cerr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lv4[i]) cnt4[i] = cnt4[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] a [4];
        a[0] = 32'hA0; a[1] = 32'hA1; a[2] = 32'hA2; a[3] = 32'hA3;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) cnt4[i] = 0;
        rst2 = 1'b1; rst4 = 1'b1;
        en2 = 0; din2 = 0; vin2 = 0; cr2 = 0;
        en4 = 0; din4 = 0; vin4 = 0; cr4 = 0;
        #2;
        rst2 = 1'b0; rst4 = 1'b0;
        #1;
        chk("rst_lv", 32'(lv2), 32'd0);
        chk("rst_ld", ld2, 32'd0);
        chk("rst_rdy", 32'(rdy2), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_cerr", 32'(cerr2), 32'd0);
        tick();
        tick();
        rst2 = 1'b1; rst4 = 1'b1;
        en2 = 1'b1;
        tick();
        chk("run_busy", 32'(busy2), 32'd1);
        chk("run_rdy", 32'(rdy2), 32'd1);

        // basic striping, downstream frees each slot right away
        vin2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din2 = a[i];
            tick();
            chk("bas_lv", 32'(lv2), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("bas_ld", ld2, a[i]);
            chk("bas_rdy", 32'(rdy2), 32'd1);
            cr2 = (i % 2 == 0) ? 2'b01 : 2'b10;
        end
        vin2 = 1'b0;
        tick();
        chk("bas_idle_lv", 32'(lv2), 32'd0);
        cr2 = 2'b00;

        // credit stall: 8 words fit, ninth stalls on lane 0
        vin2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din2 = 32'hB0 + 32'(i);
            tick();
            chk("stl_lv", 32'(lv2), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("stl_ld", ld2, 32'hB0 + 32'(i));
        end
        chk("stl_rdy0", 32'(rdy2), 32'd0);
        din2 = 32'hB8;
        tick();
        chk("stl_hold_lv", 32'(lv2), 32'd0);
        chk("stl_hold_ld", ld2, 32'hB7);
        cr2 = 2'b01;
        tick();
        cr2 = 2'b00;
        #1;
        chk("stl_rel_rdy", 32'(rdy2), 32'd1);
        tick();
        chk("stl_rel_lv", 32'(lv2), 32'd1);
        chk("stl_rel_ld", ld2, 32'hB8);
        chk("stl_rdy1", 32'(rdy2), 32'd0);
        tick();
        chk("stl_one_lv", 32'(lv2), 32'd0);
        vin2 = 1'b0;

        // refill lane 1 to 4, lane 0 to 1 (ptr sits at lane 1)
        cr2 = 2'b10;
        repeat (4) tick();
        cr2 = 2'b01;
        tick();
        cr2 = 2'b00;

        // same-cycle return and consume on lane 0 at credit 1
        vin2 = 1'b1;
        din2 = 32'hC0;
        tick();
        chk("sim_lv0", 32'(lv2), 32'd2);
        din2 = 32'hC1;
        cr2  = 2'b01;
        tick();
        cr2 = 2'b00;
        chk("sim_lv1", 32'(lv2), 32'd1);
        chk("sim_ld1", ld2, 32'hC1);
        din2 = 32'hC2;
        tick();
        vin2 = 1'b0;
        #1;
        chk("sim_rdy", 32'(rdy2), 32'd1);
        chk("sim_cerr", 32'(cerr2), 32'd0);
        tick();

        // over-return on lane 1 (c0=1, c1=2 here)
        cr2 = 2'b11;
        tick();
        tick();
        chk("ovr_pre", 32'(cerr2), 32'd0);
        tick();
        cr2 = 2'b00;
        chk("ovr_set", 32'(cerr2), 32'd1);
        vin2 = 1'b1;
        din2 = 32'hF0;
        tick();
        din2 = 32'hF1;
        tick();
        chk("ovr_lv", 32'(lv2), 32'd2);
        chk("ovr_sticky", 32'(cerr2), 32'd1);

        // async reset between edges during RUN
        din2 = 32'hF2;
        tick();
        chk("ar_pre_lv", 32'(lv2), 32'd1);
        #2;
        rst2 = 1'b0;
        #1;
        chk("ar_lv", 32'(lv2), 32'd0);
        chk("ar_rdy", 32'(rdy2), 32'd0);
        chk("ar_busy", 32'(busy2), 32'd0);
        chk("ar_cerr", 32'(cerr2), 32'd0);
        #2;
        rst2 = 1'b1;
        din2 = 32'hD0;
        tick();
        chk("ar_idle_lv", 32'(lv2), 32'd0);
        tick();
        chk("ar_first_lv", 32'(lv2), 32'd1);
        chk("ar_first_ld", ld2, 32'hD0);
        vin2 = 1'b0;

        // drain padding on 4 lanes
        en4 = 1'b1;
        tick();
        vin4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din4 = 32'hE0 + 32'(i);
            tick();
            chk("dr_lv", 32'(lv4), 32'd1 << (i % 4));
        end
        en4  = 1'b0;
        din4 = 32'hDEAD_BEEF;
        #1;
        chk("dr_rdy", 32'(rdy4), 32'd0);
        tick();
        chk("dr_gap_lv", 32'(lv4), 32'd0);
        chk("dr_gap_busy", 32'(busy4), 32'd1);
        tick();
        chk("dr_p1_lv", 32'(lv4), 32'd2);
        chk("dr_p1_ld", ld4, 32'hBCBC_BCBC);
        tick();
        chk("dr_p2_lv", 32'(lv4), 32'd4);
        chk("dr_p2_busy", 32'(busy4), 32'd1);
        tick();
        chk("dr_p3_lv", 32'(lv4), 32'd8);
        chk("dr_p3_ld", ld4, 32'hBCBC_BCBC);
        chk("dr_p3_busy", 32'(busy4), 32'd0);
        vin4 = 1'b0;
        tick();
        chk("dr_end_lv", 32'(lv4), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("dr_count", 32'(cnt4[i]), 32'd2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
